base_endian_sched: RTL

- Round-robin scheduler that shares one byte-swap datapath between `ways` requesters.
- Each requester presents a data beat and a per-beat swap flag. The winner's beat is optionally byte-reversed and captured into a single registered output stage with a valid/ready handshake.
- Sits between multiple host/DMA streams and a single downstream consumer that needs a uniform byte order.

---
 rtl/base_endian_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/base_endian_sched.sv
// ============================================================================
// Module   : base_endian_sched
// Purpose  : Round-robin arbiter in front of one shared byte-swap datapath,
//            with a single registered valid/ready output stage.
// Option   : BASE_ENDIAN_SCHED_LOCK_EN adds i_last/o_last packet locking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module base_endian_sched #(
  parameter  int BYTES = 8,
  parameter  int WAYS  = 2,
  localparam int W     = 8 * BYTES,
  localparam int SW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [WAYS-1:0]   i_v,
  output logic [WAYS-1:0]   o_r,
  input  logic [WAYS*W-1:0] i_d,
  input  logic [WAYS-1:0]   i_swap,
`ifdef BASE_ENDIAN_SCHED_LOCK_EN
  input  logic [WAYS-1:0]   i_last,
  output logic              o_last,
`endif
  output logic              o_v,
  input  logic              i_r,
  output logic [W-1:0]      o_d,
  output logic [SW-1:0]     o_src
);

  logic          r_v;
  logic [W-1:0]  r_d;
  logic [SW-1:0] r_src;
  logic [SW-1:0] r_ptr;

  logic          w_rr_found;
  logic [SW-1:0] w_rr_gnt;
  logic          w_found;
  logic [SW-1:0] w_gnt;
  logic          w_load;
  logic [SW-1:0] w_ptr_next;
  logic [W-1:0]  w_beat;
  logic [W-1:0]  w_rev;
  logic [W-1:0]  w_next_d;

  // First valid requester at or after the pointer, wrapping modulo WAYS.
  always_comb begin
    int idx;
    idx        = 0;
    w_rr_found = 1'b0;
    w_rr_gnt   = '0;
    for (int i = 0; i < WAYS; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= WAYS) idx = idx - WAYS;
      if (!w_rr_found && i_v[idx]) begin
        w_rr_found = 1'b1;
        w_rr_gnt   = SW'(idx);
      end
    end
  end

`ifdef BASE_ENDIAN_SCHED_LOCK_EN
  logic r_locked;
  logic r_last;

  // While a packet is open, the owner is the last granted requester (r_src).
  assign w_found = r_locked ? i_v[r_src] : w_rr_found;
  assign w_gnt   = r_locked ? r_src : w_rr_gnt;
  assign o_last  = r_last;
`else
  assign w_found = w_rr_found;
  assign w_gnt   = w_rr_gnt;
`endif

  assign w_load     = i_rst_n & w_found & (~r_v | i_r);
  assign w_ptr_next = (w_gnt == SW'(WAYS - 1)) ? '0 : w_gnt + 1'b1;

  always_comb begin
    o_r = '0;
    if (w_load) o_r[w_gnt] = 1'b1;
  end

  // Requester 0 sits in the most significant slice of i_d.
  assign w_beat = i_d[(WAYS - 1 - int'(w_gnt)) * W +: W];

  always_comb begin
    w_rev = '0;
    for (int j = 0; j < BYTES; j++) begin
      w_rev[8*j +: 8] = w_beat[8*(BYTES-1-j) +: 8];
    end
  end

  assign w_next_d = i_swap[w_gnt] ? w_rev : w_beat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v      <= 1'b0;
      r_d      <= '0;
      r_src    <= '0;
      r_ptr    <= '0;
`ifdef BASE_ENDIAN_SCHED_LOCK_EN
      r_locked <= 1'b0;
      r_last   <= 1'b0;
`endif
    end else if (w_load) begin
      r_v   <= 1'b1;
      r_d   <= w_next_d;
      r_src <= w_gnt;
`ifdef BASE_ENDIAN_SCHED_LOCK_EN
      r_last <= i_last[w_gnt];
      if (i_last[w_gnt]) begin
        r_locked <= 1'b0;
        r_ptr    <= w_ptr_next;
      end else begin
        r_locked <= 1'b1;
      end
`else
      r_ptr <= w_ptr_next;
`endif
    end else if (i_r) begin
      r_v <= 1'b0;
    end
  end

  assign o_v   = r_v;
  assign o_d   = r_d;
  assign o_src = r_src;

endmodule

`default_nettype wire
